// File: rtl/key_event_gen.sv
// Turns debounced active-low key levels into one-clock press, repeat and long-press events.
// Optional feature: define KEY_EVENT_REPEAT_EN to build auto-repeat for REPEAT_MASK keys.
module key_event_gen #(
   parameter int                N_KEYS        = 4,
   parameter int                HOLD_CYCLES   = 25_000_000,
   parameter int                REPEAT_CYCLES = 5_000_000,
   parameter logic [N_KEYS-1:0] REPEAT_MASK   = 4'b1100
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_KEYS-1:0] key_n,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_long,
   output logic [N_KEYS-1:0] key_held
);

   localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX);

   typedef logic [CNT_W-1:0] cnt_t;
   typedef enum logic [1:0] {IDLE, HOLD, REPEAT, WAIT_REL} state_t;

   localparam cnt_t HOLD_LAST = cnt_t'(HOLD_CYCLES - 1);

`ifdef KEY_EVENT_REPEAT_EN
   localparam logic [N_KEYS-1:0] RPT_KEYS = REPEAT_MASK;
   localparam cnt_t              RPT_LAST = cnt_t'(REPEAT_CYCLES - 1);
`else
   // Without the repeat build every key takes the long-press path.
   localparam logic [N_KEYS-1:0] RPT_KEYS = REPEAT_MASK & {N_KEYS{1'b0}};
`endif

   logic [N_KEYS-1:0] key_prev;
   state_t            state [N_KEYS];
   cnt_t              cnt   [N_KEYS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // Reset looks like "already pressed" so a key held through reset stays silent.
         key_prev  <= '0;
         key_press <= '0;
         key_long  <= '0;
         key_held  <= '0;
         for (int i = 0; i < N_KEYS; i++) begin
            state[i] <= IDLE;
            cnt[i]   <= '0;
         end
      end else begin
         key_prev <= key_n;
         key_held <= ~key_n;
         // NOTE: pulses default to 0 here and per-key bits override below; the last
         // non-blocking assignment to a bit wins, which guarantees one-cycle pulses.
         key_press <= '0;
         key_long  <= '0;
         for (int i = 0; i < N_KEYS; i++) begin
            if (key_n[i]) begin
               // Release beats any threshold reached in the same cycle.
               state[i] <= IDLE;
               cnt[i]   <= '0;
            end else begin
               case (state[i])
                  IDLE: begin
                     if (key_prev[i]) begin
                        key_press[i] <= 1'b1;
                        cnt[i]       <= '0;
                        state[i]     <= HOLD;
                     end
                  end
                  HOLD: begin
                     if (cnt[i] == HOLD_LAST) begin
                        if (RPT_KEYS[i]) begin
                           key_press[i] <= 1'b1;
                           cnt[i]       <= '0;
                           state[i]     <= REPEAT;
                        end else begin
                           key_long[i] <= 1'b1;
                           state[i]    <= WAIT_REL;
                        end
                     end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                     end
                  end
`ifdef KEY_EVENT_REPEAT_EN
                  REPEAT: begin
                     if (cnt[i] == RPT_LAST) begin
                        key_press[i] <= 1'b1;
                        cnt[i]       <= '0;
                     end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                     end
                  end
`endif
                  WAIT_REL: ;
                  default: begin
                     state[i] <= IDLE;
                     cnt[i]   <= '0;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: doc/key_event_gen.md
# key_event_gen

Converts the four debounced, active-low push-button levels into one-clock event pulses for the mode FSM and the time-set/alarm adjust logic, so that one physical press produces exactly one state step or one increment. Sits between the per-key debouncers and the top-level FSM in the 50 MHz domain. Selected keys (increase/decrease) auto-repeat while held; the other keys report a long-press event.

## Interface

Parameters:
- N_KEYS, 4: number of key channels.
- HOLD_CYCLES, 25_000_000: cycles a key must stay held after its press pulse before the first repeat pulse or long-press pulse. Legal values are 2 or more.
- REPEAT_CYCLES, 5_000_000: period of repeat pulses after the first one. Legal values are 2 or more.
- REPEAT_MASK, 4'b1100: bit i = 1 makes key i auto-repeat. Bit i = 0 makes key i report a long press.

Ports:
- clk, in, 1: system clock (CLOCK_50).
- rst, in, 1: asynchronous, active-high reset.
- key_n, in, N_KEYS: debounced key levels, already synchronous to clk. 0 = pressed.
- key_press, out, N_KEYS: one-clock pulse per press event and per repeat event.
- key_long, out, N_KEYS: one-clock pulse when a non-repeat key reaches HOLD_CYCLES.
- key_held, out, N_KEYS: registered level, 1 while the key is pressed.

## Operation

- Each key has its own independent channel: a previous-level register key_prev[i], a counter cnt[i] sized to $clog2(max(HOLD_CYCLES, REPEAT_CYCLES)), and a 2-bit state.
- Press edge: key_n[i] == 0 and key_prev[i] == 1. Release: key_n[i] == 1.
- States:
  - IDLE: on a press edge, pulse key_press[i], clear cnt, go to HOLD.
  - HOLD: cnt increments each cycle while the key stays low.
    - When cnt reaches HOLD_CYCLES-1 and REPEAT_MASK[i] = 1: pulse key_press[i], clear cnt, go to REPEAT.
    - When cnt reaches HOLD_CYCLES-1 and REPEAT_MASK[i] = 0: pulse key_long[i], go to WAIT_REL.
  - REPEAT: cnt increments. At REPEAT_CYCLES-1, pulse key_press[i] and clear cnt. Stay in REPEAT.
  - WAIT_REL: no events.
- Release in any state: go to IDLE and clear cnt. No pulse is emitted in the release cycle. A release in the same cycle as a threshold hit suppresses that pulse.
- Simultaneous presses on different keys each pulse in the same cycle. Priority between keys belongs to the consumer (the FSM ranks key 0 above key 1).
- Reset: state = IDLE, cnt = 0, key_prev = all-zeros (every key treated as already pressed), all outputs 0.
  - A key held through reset deassertion produces no event until it is released and pressed again.
  - Reset asserted mid-hold or mid-repeat aborts the sequence immediately.
- The counter saturates by construction and never wraps past its threshold.

## Timing

- All outputs are registered.
- key_press and key_held rise in the cycle after the first clk edge at which key_n[i] is sampled 0 (latency 1).
- First repeat or long pulse: exactly HOLD_CYCLES cycles after the initial key_press pulse.
- Subsequent repeats: every REPEAT_CYCLES cycles.
- key_held falls 1 cycle after key_n[i] is sampled 1.
- Every pulse is exactly one cycle wide. A single press never produces two adjacent pulse cycles.

## Configuration

- KEY_EVENT_REPEAT_EN defined:
  - Auto-repeat is built as described. REPEAT_MASK and REPEAT_CYCLES are honoured.
- KEY_EVENT_REPEAT_EN not defined:
  - The REPEAT state and repeat logic are not built. Every key behaves as if its REPEAT_MASK bit were 0.
  - A key pulses key_press once per press and key_long at HOLD_CYCLES.
  - REPEAT_MASK and REPEAT_CYCLES are ignored.

## Test plan

Run all scenarios with HOLD_CYCLES=8, REPEAT_CYCLES=3 and default REPEAT_MASK unless noted.

- Single tap: key_n[0] low for 4 cycles, then high.
  - Expect exactly one key_press[0] pulse, 1 cycle after the low sample.
  - key_held[0] is high for 4 cycles. No key_long pulse.
- Repeat: key_n[2] held low for 20 cycles.
  - key_press[2] pulses at relative cycles 0, 8, 11, 14, 17, counted from the first pulse.
  - No pulse after release.
- Long press: key_n[1] held low for 15 cycles.
  - key_press[1] pulses at cycle 0 and key_long[1] pulses at cycle 8. Nothing else.
- Simultaneous press: key_n = 4'b0110 in one cycle.
  - key_press = 4'b1001 for one cycle, then 0.
- Reset with key held: key_n[3] held low while rst pulses.
  - All outputs read 0 during reset. No event after reset deassertion.
  - After the key is released and pressed again, one key_press[3] pulse.
- Macro off (KEY_EVENT_REPEAT_EN undefined): key_n[2] held low for 20 cycles.
  - key_press[2] pulses at cycle 0 only. key_long[2] pulses at cycle 8.
